// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, controller state type and a width helper.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vga_state_e;

  // Address width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-MOD up-counter for one raster axis; wrap flags the tick that returns to 0.
module vga_axis_counter #(
  parameter int MOD = 800,
  parameter int W   = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign wrap = tick && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: issues pixel-memory reads and re-aligns syncs/DE with
// the returned pixel data after a fixed read latency.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | counters parked at 0, outputs blank, syncs inactive
//   ST_RUN   | raster running, en held high
//   ST_DRAIN | en dropped; finish the current frame, then go idle
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int RD_LAT   = 1,
  parameter int COLOR_W  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              pix_en,
  input  logic                              en,
  input  logic [3*COLOR_W-1:0]              din,
  output logic [clog2_min1(V_ACTIVE)-1:0]   row,
  output logic [clog2_min1(H_ACTIVE)-1:0]   col,
  output logic                              rd_req,
  output logic [COLOR_W-1:0]                r,
  output logic [COLOR_W-1:0]                g,
  output logic [COLOR_W-1:0]                b,
  output logic                              hs,
  output logic                              vs,
  output logic                              de,
  output logic                              frame_start,
  output logic                              line_start,
  output logic                              running
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW = clog2_min1(H_TOTAL);
  localparam int VW = clog2_min1(V_TOTAL);
  localparam int CW = clog2_min1(H_ACTIVE);
  localparam int RW = clog2_min1(V_ACTIVE);

  localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_LO   = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_HI   = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_LO   = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_HI   = VW'(V_SYNC + V_BP + V_ACTIVE);

  localparam logic HS_ON  = (HS_POL != 0);
  localparam logic HS_OFF = !HS_ON;
  localparam logic VS_ON  = (VS_POL != 0);
  localparam logic VS_OFF = !VS_ON;

  vga_state_e state, state_nx;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap, v_wrap;
  logic          active, h_tick, in_act;

  // Index 0 is the address-phase stage; index RD_LAT lines up with captured din.
  logic hs_p [0:RD_LAT];
  logic vs_p [0:RD_LAT];
  logic de_p [0:RD_LAT];
  logic [3*COLOR_W-1:0] rgb_q;

  assign active = (state != ST_IDLE);
  assign h_tick = pix_en && active;
  assign in_act = active
                  && (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI)
                  && (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI);

  vga_axis_counter #(.MOD(H_TOTAL), .W(HW)) u_h_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (h_tick),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(.MOD(V_TOTAL), .W(VW)) u_v_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (h_wrap),
    .count (v_cnt),
    .wrap  (v_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // v_wrap already implies a pix_en tick on the last pixel of the frame.
  always_comb begin
    state_nx = state;
    if (pix_en) begin
      case (state)
        ST_IDLE:  if (en) state_nx = ST_RUN;
        ST_RUN:   if (!en) state_nx = ST_DRAIN;
        ST_DRAIN: begin
          if (en) begin
            state_nx = ST_RUN;
          end else if (v_wrap) begin
            state_nx = ST_IDLE;
          end
        end
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        hs_p[i] <= HS_OFF;
        vs_p[i] <= VS_OFF;
        de_p[i] <= 1'b0;
      end
      row         <= '0;
      col         <= '0;
      rgb_q       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (pix_en) begin
      hs_p[0]     <= (active && (h_cnt < H_SYNC_END)) ? HS_ON : HS_OFF;
      vs_p[0]     <= (active && (v_cnt < V_SYNC_END)) ? VS_ON : VS_OFF;
      de_p[0]     <= in_act;
      row         <= in_act ? RW'(v_cnt - V_ACT_LO) : '0;
      col         <= in_act ? CW'(h_cnt - H_ACT_LO) : '0;
      frame_start <= active && (h_cnt == '0) && (v_cnt == '0);
      line_start  <= active && (h_cnt == '0);
      for (int i = 1; i <= RD_LAT; i++) begin
        hs_p[i] <= hs_p[i-1];
        vs_p[i] <= vs_p[i-1];
        de_p[i] <= de_p[i-1];
      end
      rgb_q <= de_p[RD_LAT-1] ? din : '0;
    end else begin
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end
  end

  assign rd_req  = de_p[0];
  assign hs      = hs_p[RD_LAT];
  assign vs      = vs_p[RD_LAT];
  assign de      = de_p[RD_LAT];
  assign r       = rgb_q[COLOR_W-1:0];
  assign g       = rgb_q[2*COLOR_W-1:COLOR_W];
  assign b       = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign running = active;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster with a latency-3 pixel memory.
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 16, H_FP = 3, H_SYNC = 4, H_BP = 5;
  localparam int V_ACTIVE = 6,  V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int HS_POL = 1, VS_POL = 0, RD_LAT = 3, COLOR_W = 4;
  localparam int HT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int VT = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int FT = HT * VT;
  localparam int CW = $clog2(H_ACTIVE);
  localparam int RW = $clog2(V_ACTIVE);
  localparam int MI = (RD_LAT > 1) ? RD_LAT - 2 : 0;
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  logic clk = 1'b0, rst_n, pix_en, en;
  logic [3*COLOR_W-1:0] din;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic rd_req, hs, vs, de, frame_start, line_start, running;
  logic [COLOR_W-1:0] r, g, b;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .RD_LAT(RD_LAT), .COLOR_W(COLOR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .en(en), .din(din),
    .row(row), .col(col), .rd_req(rd_req), .r(r), .g(g), .b(b),
    .hs(hs), .vs(vs), .de(de), .frame_start(frame_start),
    .line_start(line_start), .running(running)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic rd; logic [RW-1:0] row; logic [CW-1:0] col; logic hs, vs, fs, ls;
  } s0_t;

  typedef struct {
    logic rd; logic [RW-1:0] row; logic [CW-1:0] col;
    logic hs, vs, de; logic [3*COLOR_W-1:0] rgb; logic fs, ls, run;
  } exp_t;

  int n_chk = 0, n_fail = 0;
  int stride = 1;
  logic [3:0] seed;
  exp_t exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at t=%0t", name, act, want, $time);
    end
  endtask

  // Pixel memory contents: each field derived from the pixel coordinate.
  function automatic logic [3*COLOR_W-1:0] pat(input logic [RW-1:0] rr, input logic [CW-1:0] cc,
                                               input logic [3:0] sd);
    return {4'(rr + cc + sd), 4'(rr), 4'(cc)};
  endfunction

  // Memory model: data for an address appears RD_LAT ticks after the request.
  logic [RW+CW:0] mh [0:3];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mh[i] <= '0;
    end else if (pix_en) begin
      mh[0] <= {rd_req, row, col};
      for (int i = 1; i < 4; i++) mh[i] <= mh[i-1];
    end
  end
  logic [RW+CW:0] maddr;
  assign maddr = (RD_LAT == 1) ? {rd_req, row, col} : mh[MI];
  assign din = maddr[RW+CW] ? pat(maddr[RW+CW-1:CW], maddr[CW-1:0], seed) : 12'hA5A;

  function automatic s0_t stage0_at(input int pos);
    int h, v;
    s0_t s;
    h = pos % HT;
    v = pos / HT;
    s.hs  = (h < H_SYNC) ? HS_ON : !HS_ON;
    s.vs  = (v < V_SYNC) ? VS_ON : !VS_ON;
    s.rd  = (h >= H_SYNC + H_BP) && (h < H_SYNC + H_BP + H_ACTIVE)
         && (v >= V_SYNC + V_BP) && (v < V_SYNC + V_BP + V_ACTIVE);
    s.row = s.rd ? RW'(v - V_SYNC - V_BP) : '0;
    s.col = s.rd ? CW'(h - H_SYNC - H_BP) : '0;
    s.fs  = (pos == 0);
    s.ls  = (h == 0);
    return s;
  endfunction

  function automatic s0_t blank();
    s0_t s;
    s = '0;
    s.hs = !HS_ON;
    s.vs = !VS_ON;
    return s;
  endfunction

  // Reference model: raster position as a single frame index plus a stop request.
  initial begin
    bit   m_active, m_drain;
    int   m_pos;
    s0_t  hist [0:RD_LAT-1];
    s0_t  s0, al;
    exp_t e, e_last;
    m_active = 0; m_drain = 0; m_pos = 0;
    for (int i = 0; i < RD_LAT; i++) hist[i] = blank();
    e_last = '{default: '0};
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_active = 0; m_drain = 0; m_pos = 0;
        for (int i = 0; i < RD_LAT; i++) hist[i] = blank();
        e = '{default: '0};
        e.hs = !HS_ON;
        e.vs = !VS_ON;
      end else if (pix_en) begin
        s0 = blank();
        if (m_active) begin
          s0 = stage0_at(m_pos);
          if (m_drain && !en && m_pos == FT - 1) m_active = 0;
          m_drain = m_active && !en;
          m_pos = (m_pos + 1) % FT;
        end else if (en) begin
          m_active = 1; m_drain = 0; m_pos = 0;
        end
        al = hist[RD_LAT-1];
        for (int i = RD_LAT - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = s0;
        e.rd = s0.rd; e.row = s0.row; e.col = s0.col; e.fs = s0.fs; e.ls = s0.ls;
        e.hs = al.hs; e.vs = al.vs; e.de = al.rd;
        e.rgb = al.rd ? pat(al.row, al.col, seed) : '0;
        e.run = m_active;
      end else begin
        e = e_last;
        e.fs = 0;
        e.ls = 0;
      end
      e_last = e;
      exp_q.push_back(e);
    end
  end

  // Monitor: one expected entry per clock, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("addr",   {rd_req, row, col},                {e.rd, e.row, e.col});
        chk("sync",   {hs, vs, de},                      {e.hs, e.vs, e.de});
        chk("rgb",    {b, g, r},                         e.rgb);
        chk("status", {frame_start, line_start, running}, {e.fs, e.ls, e.run});
      end
    end
  end

  // Pixel strobe: every stride-th clock, or random when stride is 0.
  initial begin
    int cyc;
    cyc = 0;
    pix_en = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (stride == 0) pix_en = ($urandom_range(0, 2) != 0);
      else             pix_en = ((cyc % stride) == 0);
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs(input int limit);
    bit got;
    got = 0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (frame_start) got = 1;
    end
    chk("frame_start_seen", got, 1);
  endtask

  task automatic measure_period(input int want);
    int n;
    bit got;
    wait_fs(3 * want);
    n = 0;
    got = 0;
    while (!got && n < 3 * want) begin
      @(negedge clk);
      n++;
      if (frame_start) got = 1;
    end
    chk("frame_period", n, want);
  endtask

  task automatic check_reset_values();
    chk("rst_addr",   {rd_req, row, col}, 0);
    chk("rst_sync",   {hs, vs, de}, {!HS_ON, !VS_ON, 1'b0});
    chk("rst_rgb",    {b, g, r}, 0);
    chk("rst_status", {frame_start, line_start, running}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  initial begin
    seed = 4'($urandom);
    rst_n = 1'b1;
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(5);

    en = 1'b1;
    measure_period(FT);

    stride = 4;
    measure_period(4 * FT);
    stride = 1;

    wait_fs(2 * FT);
    wait_clks(HT * 5);
    en = 1'b0;
    wait_clks(2 * FT);
    chk("idle_after_drain", running, 0);

    en = 1'b1;
    wait_fs(2 * FT);
    wait_clks(HT * 3);
    en = 1'b0;
    wait_clks(HT * 2);
    en = 1'b1;
    wait_clks(FT + HT);

    stride = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 149) == 0) en = !en;
    end

    stride = 1;
    en = 1'b1;
    wait_fs(4 * FT);
    wait_clks(HT * 2 + 7);
    #1 rst_n = 1'b0;
    #1 check_reset_values();
    wait_clks(2);
    rst_n = 1'b1;
    measure_period(FT);
    wait_clks(HT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameters HS_POL, VS_POL, default 0 each, giving the sync asserted level (0 = active-low).
REQ-006 SHALL have parameter RD_LAT, default 1, range 1..4, pixel-memory read latency in pix_en ticks.
REQ-007 SHALL have parameter COLOR_W, default 4, bits per colour channel.
REQ-008 SHALL have port clk, input, 1 bit, the single clock.
REQ-009 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-010 SHALL have port pix_en, input, 1 bit, pixel-rate strobe; all state advances only when it is high.
REQ-011 SHALL have port en, input, 1 bit, run request.
REQ-012 SHALL have port din, input, 3*COLOR_W bits, pixel data packed {B,G,R}, R in the LSBs.
REQ-013 SHALL have port row, output, clog2(V_ACTIVE) bits, read row address.
REQ-014 SHALL have port col, output, clog2(H_ACTIVE) bits, read column address.
REQ-015 SHALL have port rd_req, output, 1 bit, active-high read strobe.
REQ-016 SHALL have ports r, g, b, output, COLOR_W bits each, colour outputs.
REQ-017 SHALL have ports hs, vs, de, output, 1 bit each, syncs and data enable.
REQ-018 SHALL have ports frame_start, line_start, running, output, 1 bit each, status.

Function
REQ-019 SHALL define H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL likewise, with segment order sync, back porch, active, front porch from count 0.
REQ-020 SHALL increment h_cnt on each pix_en tick in RUN/DRAIN, wrap at H_TOTAL-1 to 0, and increment v_cnt on that wrap, wrapping at V_TOTAL-1 to 0.
REQ-021 SHALL register rd_req=1 exactly when h_cnt is within [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v_cnt is within [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE), with row/col equal to the counts minus those offsets, and zero row/col otherwise.
REQ-022 SHALL treat din as valid RD_LAT pix_en ticks after the corresponding rd_req tick.
REQ-023 SHALL delay hs, vs and de through RD_LAT pix_en stages so they are aligned with the captured din; r/g/b SHALL be din when aligned de=1, else 0.
REQ-024 SHALL assert hs at level HS_POL while h_cnt < H_SYNC, and vs at level VS_POL while v_cnt < V_SYNC, otherwise the inverse level.
REQ-025 SHALL pulse frame_start for one clk on the pix_en tick where h_cnt=0 and v_cnt=0, and line_start for one clk on every tick where h_cnt=0, both unaligned (stage 0).
REQ-026 SHALL implement FSM IDLE, RUN, DRAIN; IDLE->RUN on pix_en with en=1, counters starting at 0.
REQ-027 SHALL go RUN->DRAIN when en=0; DRAIN->RUN when en=1 with no counter disturbance.
REQ-028 SHALL go DRAIN->IDLE on the tick h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, so frames are never truncated.
REQ-029 SHALL hold counters at 0, rd_req/de/r/g/b at 0 and hs/vs at the inactive level in IDLE; running=1 in RUN and DRAIN.
REQ-030 SHALL freeze all state, including pipeline stages, while pix_en=0.

Reset
REQ-031 SHALL on rst_n=0, asynchronously and mid-frame included, force state IDLE, counters 0, pipeline cleared, rd_req/de/r/g/b/frame_start/line_start/running 0, and hs/vs at the inactive level.
REQ-032 SHALL leave IDLE after reset release only via REQ-026.

Structure
REQ-033 SHALL place the default 640x480 timing constants and the FSM state enum in the shared package vga_pkg.
REQ-034 SHALL use one sub-module, vga_axis_counter (modulus parameter, tick-enable in, count and wrap out), instanced for both axes.

Verification
REQ-035 Reset, en=1, pix_en=1 every clk -> frame_start period is 800*525=420000 clks; hs low for 96 of every 800 ticks; vs low for 2 lines.
REQ-036 din=count-of-col pattern, RD_LAT=3 -> first de=1 three ticks after first rd_req, with r equal to col 0 data; 640 de ticks per line, 480 lines.
REQ-037 en dropped at v_cnt=100 -> running stays 1 until the tick h_cnt=799, v_cnt=524, then IDLE with hs/vs inactive.
REQ-038 en dropped then reasserted within DRAIN -> counters continuous, no extra frame_start.
REQ-039 pix_en high every 4th clk -> all timing scales exactly 4x and outputs stay constant between strobes.
REQ-040 rst_n pulsed low mid-line -> outputs take reset values within the same clk with no clock edge, and the next frame_start follows a restart at h_cnt=0, v_cnt=0.
